// File: rtl/fetch_pc.sv
// Fetch program counter with trap/branch/return redirects, sequential advance,
// sticky overflow, alignment guard and an optional return-address stack.
// Optional feature macro: FETCH_PC_RAS_EN compiles in the return-address stack.
module fetch_pc #(
   parameter int              XLEN      = 32,
   parameter logic [XLEN-1:0] BASE_ADDR = XLEN'(32'h0000_0000),
   parameter logic [XLEN-1:0] MAX_ADDR  = XLEN'(32'h0000_FFFF),
   parameter int              INC       = 4,
   parameter int              RAS_DEPTH = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            clk_en,
   input  logic            trap,
   input  logic [XLEN-1:0] trap_vec,
   input  logic            load,
   input  logic [XLEN-1:0] loaded,
   input  logic            call,
   input  logic            ret,
   input  logic            pc_ready,
   output logic            pc_valid,
   output logic [XLEN-1:0] address,
   output logic            ovf,
   output logic            misalign,
   output logic            ras_empty
);

   localparam logic [XLEN-1:0] INC_X      = XLEN'(INC);
   localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'(INC - 1);
   localparam logic [XLEN-1:0] SEQ_LIMIT  = MAX_ADDR - INC_X + XLEN'(1);

   logic            ras_has;
   logic [XLEN-1:0] ras_top;
   logic            redirect;
   logic [XLEN-1:0] target;
   logic            want_push;
   logic            want_pop;
   logic            target_bad;
   logic            ras_push;
   logic            ras_pop;

`ifdef FETCH_PC_RAS_EN
   localparam int PW = $clog2(RAS_DEPTH);
   localparam int CW = PW + 1;

   logic [XLEN-1:0] ras_mem [RAS_DEPTH];
   logic [PW-1:0]   ras_ptr;
   logic [CW-1:0]   ras_count;

   assign ras_has   = (ras_count != '0);
   assign ras_top   = ras_mem[ras_ptr - PW'(1)];
   assign ras_empty = ~ras_has;

   // Stack pointer and occupancy; a push onto a full stack overwrites the oldest entry
   always_ff @(posedge clk) begin
      if (rst) begin
         ras_ptr   <= '0;
         ras_count <= '0;
      end else if (clk_en) begin
         if (ras_push) begin
            ras_ptr <= ras_ptr + PW'(1);
            if (ras_count != CW'(RAS_DEPTH)) begin
               ras_count <= ras_count + CW'(1);
            end
         end else if (ras_pop) begin
            ras_ptr   <= ras_ptr - PW'(1);
            ras_count <= ras_count - CW'(1);
         end
      end
   end

   // Return-address storage, written at the current top on each accepted push
   always_ff @(posedge clk) begin
      if (!rst && clk_en && ras_push) begin
         ras_mem[ras_ptr] <= address + INC_X;
      end
   end
`else
   logic unused_ras;

   assign unused_ras = ^{call, ret};
   assign ras_has    = 1'b0;
   assign ras_top    = '0;
   assign ras_empty  = 1'b1;
`endif

   // Pick the winning redirect (trap > load > ret) and the stack action it implies
   always_comb begin
      redirect  = 1'b0;
      target    = '0;
      want_push = 1'b0;
      want_pop  = 1'b0;
      if (trap) begin
         redirect = 1'b1;
         target   = trap_vec;
      end else if (load) begin
         redirect = 1'b1;
         target   = loaded;
`ifdef FETCH_PC_RAS_EN
         want_push = call;
`endif
      end else if (ret && ras_has) begin
         redirect = 1'b1;
         target   = ras_top;
         want_pop = 1'b1;
      end
      target_bad = ((target & ALIGN_MASK) != '0);
      ras_push   = want_push & ~target_bad;
      ras_pop    = want_pop & ~target_bad;
   end

   // Address, valid, overflow and misalign state; misaligned targets are refused
   always_ff @(posedge clk) begin
      if (rst) begin
         address  <= BASE_ADDR;
         pc_valid <= 1'b1;
         ovf      <= 1'b0;
         misalign <= 1'b0;
      end else if (clk_en) begin
         misalign <= 1'b0;
         if (redirect) begin
            if (target_bad) begin
               misalign <= 1'b1;
            end else begin
               address <= target;
               if (target > MAX_ADDR) begin
                  ovf      <= 1'b1;
                  pc_valid <= 1'b0;
               end else begin
                  ovf      <= 1'b0;
                  pc_valid <= 1'b1;
               end
            end
         end else if (pc_valid && pc_ready) begin
            if (address < SEQ_LIMIT) begin
               address <= address + INC_X;
            end else begin
               ovf      <= 1'b1;
               pc_valid <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_fetch_pc.sv
// Directed scoreboard bench for fetch_pc; each step queues its expected outputs
// and the values are popped and compared one cycle after the step is applied.
module tb_fetch_pc;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        clk_en = 1'b0;
   logic        trap = 1'b0;
   logic [31:0] trap_vec = '0;
   logic        load = 1'b0;
   logic [31:0] loaded = '0;
   logic        call = 1'b0;
   logic        ret = 1'b0;
   logic        pc_ready = 1'b0;
   logic        pc_valid;
   logic [31:0] address;
   logic        ovf;
   logic        misalign;
   logic        ras_empty;

   typedef struct {
      int          step;
      logic [31:0] addr;
      logic        valid;
      logic        ovf;
      logic        mis;
      logic        empty;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;
   int   stepNo = 0;

   fetch_pc dut (
      .clk       (clk),
      .rst       (rst),
      .clk_en    (clk_en),
      .trap      (trap),
      .trap_vec  (trap_vec),
      .load      (load),
      .loaded    (loaded),
      .call      (call),
      .ret       (ret),
      .pc_ready  (pc_ready),
      .pc_valid  (pc_valid),
      .address   (address),
      .ovf       (ovf),
      .misalign  (misalign),
      .ras_empty (ras_empty)
   );

   always #5 clk = ~clk;

   // Pop the oldest expectation and compare every observable output against it
   task automatic checkOutput();
      exp_t e;
      if (sb.size() == 0) begin
         checks++;
         errors++;
         $display("[TB] FAIL scoreboard_empty got 0 entries required 1");
         return;
      end
      e = sb.pop_front();
      checks++;
      assert (address === e.addr) else begin
         errors++;
         $error("[TB] FAIL step%0d address got %h required %h", e.step, address, e.addr);
      end
      checks++;
      assert (pc_valid === e.valid) else begin
         errors++;
         $error("[TB] FAIL step%0d pc_valid got %b required %b", e.step, pc_valid, e.valid);
      end
      checks++;
      assert (ovf === e.ovf) else begin
         errors++;
         $error("[TB] FAIL step%0d ovf got %b required %b", e.step, ovf, e.ovf);
      end
      checks++;
      assert (misalign === e.mis) else begin
         errors++;
         $error("[TB] FAIL step%0d misalign got %b required %b", e.step, misalign, e.mis);
      end
      checks++;
      assert (ras_empty === e.empty) else begin
         errors++;
         $error("[TB] FAIL step%0d ras_empty got %b required %b", e.step, ras_empty, e.empty);
      end
   endtask

   // Drive one cycle of inputs, queue the expected result, then check after the edge
   task automatic applyStimulus(
      input logic        r,
      input logic        ce,
      input logic        tr,
      input logic [31:0] tv,
      input logic        ld,
      input logic [31:0] lv,
      input logic        cl,
      input logic        rt,
      input logic        pr,
      input logic [31:0] ea,
      input logic        ev,
      input logic        eo,
      input logic        em,
      input logic        ee
   );
      exp_t e;
      stepNo++;
      rst      = r;
      clk_en   = ce;
      trap     = tr;
      trap_vec = tv;
      load     = ld;
      loaded   = lv;
      call     = cl;
      ret      = rt;
      pc_ready = pr;
      e.step  = stepNo;
      e.addr  = ea;
      e.valid = ev;
      e.ovf   = eo;
      e.mis   = em;
      e.empty = ee;
      sb.push_back(e);
      @(posedge clk);
      #1;
      checkOutput();
   endtask

   initial begin
      @(posedge clk);
      #1;
      // Reset overrides a disabled clock enable
      applyStimulus(1,0, 0,0, 0,0, 0,0, 0,  32'h0,     1,0,0,1);
      // Sequential advance 0x4, 0x8, 0xC
      applyStimulus(0,1, 0,0, 0,0, 0,0, 1,  32'h4,     1,0,0,1);
      applyStimulus(0,1, 0,0, 0,0, 0,0, 1,  32'h8,     1,0,0,1);
      applyStimulus(0,1, 0,0, 0,0, 0,0, 1,  32'hC,     1,0,0,1);
      // clk_en low freezes, pc_ready low holds
      applyStimulus(0,0, 0,0, 1,32'h200, 0,0, 1, 32'hC, 1,0,0,1);
      applyStimulus(0,1, 0,0, 0,0, 0,0, 0,  32'hC,     1,0,0,1);
      // Last sequential slot overflows and then stays frozen
      applyStimulus(0,1, 0,0, 1,32'hFFFC, 0,0, 0, 32'hFFFC, 1,0,0,1);
      applyStimulus(0,1, 0,0, 0,0, 0,0, 1,  32'hFFFC,  0,1,0,1);
      applyStimulus(0,1, 0,0, 0,0, 0,0, 1,  32'hFFFC,  0,1,0,1);
      // Load clears overflow
      applyStimulus(0,1, 0,0, 1,32'h100, 0,0, 0, 32'h100, 1,0,0,1);
      // Trap beats load
      applyStimulus(0,1, 1,32'h80, 1,32'h200, 0,0, 0, 32'h80, 1,0,0,1);
      // Misaligned load is refused with a one-cycle pulse
      applyStimulus(0,1, 0,0, 1,32'h102, 0,0, 1, 32'h80, 1,0,1,1);
      applyStimulus(0,1, 0,0, 0,0, 0,0, 0,  32'h80,    1,0,0,1);
      // Target beyond MAX_ADDR is applied but flags overflow
      applyStimulus(0,1, 0,0, 1,32'h20000, 0,0, 1, 32'h20000, 0,1,0,1);
      applyStimulus(0,1, 1,32'h40, 0,0, 0,0, 1, 32'h40, 1,0,0,1);
      // Reset discards a simultaneous redirect
      applyStimulus(1,1, 1,32'h300, 1,32'h300, 0,0, 1, 32'h0, 1,0,0,1);
`ifdef FETCH_PC_RAS_EN
      // Call then return
      applyStimulus(0,1, 0,0, 1,32'h10, 0,0, 0,  32'h10,  1,0,0,1);
      applyStimulus(0,1, 0,0, 1,32'h400, 1,0, 0, 32'h400, 1,0,0,0);
      applyStimulus(0,1, 0,0, 0,0, 0,1, 0,       32'h14,  1,0,0,1);
      // Return on an empty stack is ignored, sequential advance proceeds
      applyStimulus(0,1, 0,0, 0,0, 0,1, 1,       32'h18,  1,0,0,1);
      // Five nested calls overflow the four-deep stack
      applyStimulus(0,1, 0,0, 1,32'h10, 0,0, 0,  32'h10,  1,0,0,1);
      applyStimulus(0,1, 0,0, 1,32'h20, 1,0, 0,  32'h20,  1,0,0,0);
      applyStimulus(0,1, 0,0, 1,32'h30, 1,0, 0,  32'h30,  1,0,0,0);
      applyStimulus(0,1, 0,0, 1,32'h40, 1,0, 0,  32'h40,  1,0,0,0);
      applyStimulus(0,1, 0,0, 1,32'h50, 1,0, 0,  32'h50,  1,0,0,0);
      applyStimulus(0,1, 0,0, 1,32'h60, 1,0, 0,  32'h60,  1,0,0,0);
      applyStimulus(0,1, 0,0, 0,0, 0,1, 0,       32'h54,  1,0,0,0);
      applyStimulus(0,1, 0,0, 0,0, 0,1, 0,       32'h44,  1,0,0,0);
      applyStimulus(0,1, 0,0, 0,0, 0,1, 0,       32'h34,  1,0,0,0);
      applyStimulus(0,1, 0,0, 0,0, 0,1, 0,       32'h24,  1,0,0,1);
      applyStimulus(0,1, 0,0, 0,0, 0,1, 1,       32'h28,  1,0,0,1);
      // Return together with load+call: load and push only
      applyStimulus(0,1, 0,0, 1,32'h500, 1,1, 0, 32'h500, 1,0,0,0);
      // Plain load with ret does not pop
      applyStimulus(0,1, 0,0, 1,32'h600, 0,1, 0, 32'h600, 1,0,0,0);
      applyStimulus(0,1, 0,0, 0,0, 0,1, 0,       32'h2C,  1,0,0,1);
`else
      // Without the stack, call and ret have no effect
      applyStimulus(0,1, 0,0, 1,32'h400, 1,0, 0, 32'h400, 1,0,0,1);
      applyStimulus(0,1, 0,0, 0,0, 0,1, 0,       32'h400, 1,0,0,1);
      applyStimulus(0,1, 0,0, 0,0, 1,1, 1,       32'h404, 1,0,0,1);
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
